// File: rtl/seg7_pkg.sv
// seg7_pkg: shared symbol codes, blanking constants and segment patterns for
// the 7-segment display blocks. Latency: n/a (constants and pure helpers).
// Backpressure: n/a.
// Contents: SYM_* symbol codes, DIGIT_OFF / SEG_OFF blank patterns,
//           SEG_TABLE (symbol -> active-low {g,f,e,d,c,b,a}), digit_sel().
package seg7_pkg;

  localparam logic [3:0] SYM_ARROW_UP   = 4'd10;
  localparam logic [3:0] SYM_ARROW_DOWN = 4'd11;
  localparam logic [3:0] SYM_BLANK      = 4'd15;

  localparam logic [3:0] DIGIT_OFF = 4'b1111;
  localparam logic [6:0] SEG_OFF   = 7'b111_1111;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'b100_0000;
  localparam logic [6:0] SEG_1    = 7'b111_1001;
  localparam logic [6:0] SEG_2    = 7'b010_0100;
  localparam logic [6:0] SEG_3    = 7'b011_0000;
  localparam logic [6:0] SEG_4    = 7'b001_1001;
  localparam logic [6:0] SEG_5    = 7'b001_0010;
  localparam logic [6:0] SEG_6    = 7'b000_0010;
  localparam logic [6:0] SEG_7    = 7'b111_1000;
  localparam logic [6:0] SEG_8    = 7'b000_0000;
  localparam logic [6:0] SEG_9    = 7'b001_0000;
  localparam logic [6:0] SEG_UP   = 7'b101_1100;
  localparam logic [6:0] SEG_DOWN = 7'b110_0011;

  // Entry 15 is the leftmost element of the concatenation; codes 12..15 are blank.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_OFF, SEG_OFF, SEG_OFF, SEG_OFF,
    SEG_DOWN, SEG_UP, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4,
    SEG_3, SEG_2, SEG_1, SEG_0
  };

  // Active-low one-hot digit enable for a slot (slot0 = rightmost = bit 0).
  function automatic logic [3:0] digit_sel(input logic [1:0] slot);
    return ~(4'b0001 << slot);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: maps a 4-bit symbol code to active-low 7-segment pattern.
// Latency: purely combinational. Backpressure: none.
// Ports: symbol[3:0] in, segments[6:0] out ({g,f,e,d,c,b,a}, 0 = lit).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] symbol,
  output logic [6:0] segments
);

  assign segments = SEG_TABLE[symbol];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes four symbol codes onto shared DIGIT/DISPLAY
// pins, snapshotting sym once per frame. Latency: outputs registered, 1 cycle
// after (slot, cnt). Backpressure: none; en low freezes the scan and blanks.
// Ports: clk, rst (sync, active-high), en, sym[15:0] (slot3..slot0 nibbles),
//        DIGIT[3:0] (active-low), DISPLAY[6:0] (active-low), frame_done (pulse).
// Option: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zeros on slots 3..1.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] sym,
  output logic [3:0]  DIGIT,
  output logic [6:0]  DISPLAY,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic [3:0]    shadow [4];

  logic       slot_end;
  logic       frame_end;
  logic [3:0] cur_sym;
  logic [6:0] dec_seg;
  logic [6:0] cur_seg;
  logic [3:0] suppress;
  logic       lit;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = en && slot_end && (slot == 2'd3);

  // Scan position and per-frame snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      slot       <= 2'd0;
      frame_done <= 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] <= SYM_BLANK;
    end else begin
      frame_done <= frame_end;
      if (en) begin
        if (slot_end) begin
          cnt  <= '0;
          slot <= slot + 2'd1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
      if (frame_end) begin
        for (int i = 0; i < 4; i++) shadow[i] <= sym[i*4 +: 4];
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // Walk from the leftmost slot: a zero is suppressed while everything to its
  // left is dark (blank code or itself a suppressed zero). Slot 0 always shows.
  always_comb begin
    logic left_dark;
    suppress  = 4'b0000;
    left_dark = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      suppress[i] = left_dark && (shadow[i] == 4'd0);
      left_dark   = left_dark && (suppress[i] || (shadow[i] >= 4'd12));
    end
  end
`else
  assign suppress = 4'b0000;
`endif

  assign cur_sym = shadow[slot];

  seg7_decode u_decode (
    .symbol   (cur_sym),
    .segments (dec_seg)
  );

  assign cur_seg = suppress[slot] ? SEG_OFF : dec_seg;

  // A slot with nothing to draw keeps its digit disabled too, so blank symbols
  // and suppressed zeros leave the whole position dark.
  assign lit = en && (cnt >= CNT_BLANK) && (cur_seg != SEG_OFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      DIGIT   <= DIGIT_OFF;
      DISPLAY <= SEG_OFF;
    end else if (lit) begin
      DIGIT   <= digit_sel(slot);
      DISPLAY <= cur_seg;
    end else begin
      DIGIT   <= DIGIT_OFF;
      DISPLAY <= SEG_OFF;
    end
  end

endmodule
